alu_rr_scheduler: RTL

//  - Shares one combinational 8-bit ALU (4-bit ctrl; x, y in; carry, out back) between NREQ requesters.
//  - Round-robin arbitration; operands are registered and held on the ALU ports for one full cycle.
//  - The result is returned on a valid/ready response channel, tagged with the requester index.
//  - Sits between the issuing units and the single alu instance.

---
 rtl/alu_rr_scheduler_pkg.sv | 37 +++
 rtl/alu_rr_scheduler_if.sv | 48 ++++
 rtl/alu_rr_scheduler_arbiter.sv | 48 ++++
 rtl/alu_rr_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the ALU round-robin scheduler:
//   - ALU opcode encodings (ADD .. EQ, plus the NOP code driven while idle)
//   - FSM state encoding for the scheduler
//   - op_is_illegal(): flags opcodes outside the ALU's defined set
// No ports (package).
// ---------------------------------------------------------------------------
package alu_sched_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_ROL = 4'b1000;
   localparam logic [3:0] OP_ROR = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;
   localparam logic [3:0] OP_EQ  = 4'b1100;
   localparam logic [3:0] OP_NOP = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Codes 1101..1111 have no ALU function behind them.
   function automatic logic op_is_illegal(input logic [3:0] ctrl);
      return (ctrl >= OP_NOP);
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_if
// Request/response bundle between the issuing units and the scheduler.
//   req_valid/req_ready  per-requester handshake (req_ready one-hot)
//   req_ctrl/x/y         packed per-requester opcode and operands
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/out/carry     response tag and captured ALU result
//   rsp_err              only when ALU_OPCHK_EN is defined
// Modports: master = issuing side, slave = scheduler.
// Optional feature macro: ALU_OPCHK_EN
// ---------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_ctrl;
   logic [W*NREQ-1:0] req_x;
   logic [W*NREQ-1:0] req_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_out;
   logic              rsp_carry;
`ifdef ALU_OPCHK_EN
   logic              rsp_err;

   modport master (
      output req_valid, req_ctrl, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_err
   );
   modport slave (
      input  req_valid, req_ctrl, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_err
   );
`else
   modport master (
      output req_valid, req_ctrl, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry
   );
   modport slave (
      input  req_valid, req_ctrl, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry
   );
`endif
endinterface

// File: rtl/alu_rr_scheduler_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ. The pointer register lives in the parent.
//   req    in   NREQ  request vector
//   ptr    in   IDW   highest-priority index
//   grant  out  NREQ  one-hot grant (all zero when no request)
//   gid    out  IDW   binary index of the grant (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gid
);

   // Scan NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      int           pos_s;
      logic [IDW-1:0] idx_s;
      logic         found_s;
      grant   = '0;
      gid     = '0;
      found_s = 1'b0;
      pos_s   = 0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos_s = int'(ptr) + k;
         if (pos_s >= NREQ) begin
            pos_s = pos_s - NREQ;
         end else begin
            pos_s = pos_s;
         end
         idx_s = pos_s[IDW-1:0];
         if (!found_s && req[idx_s]) begin
            found_s      = 1'b1;
            grant[idx_s] = 1'b1;
            gid          = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU among NREQ requesters with round-robin
// arbitration. One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
// Operands are registered and presented to the ALU for the whole EXEC
// cycle; the result is captured and returned on a valid/ready channel
// tagged with the requester index.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        alu_rr_scheduler_if.slave (request + response channels)
//   busy       high whenever the FSM is not idle
//   alu_ctrl   opcode to the ALU (NOP outside EXEC)
//   alu_x/y    operands to the ALU (hold last values outside EXEC)
//   alu_carry  carry from the ALU, passed through untouched
//   alu_out    result from the ALU
// Optional feature macro: ALU_OPCHK_EN -- illegal opcodes (1101..1111)
// bypass EXEC and answer one cycle after grant with rsp_err = 1.
// ---------------------------------------------------------------------------
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_rr_scheduler_if.slave    bus,
   output logic                 busy,
   output logic [3:0]           alu_ctrl,
   output logic [W-1:0]         alu_x,
   output logic [W-1:0]         alu_y,
   input  logic                 alu_carry,
   input  logic [W-1:0]         alu_out
);

   state_t          state_r;
   state_t          state_s;
   logic [IDW-1:0]  ptr_r;
   logic [IDW-1:0]  op_id_r;
   logic [3:0]      alu_ctrl_r;
   logic [W-1:0]    alu_x_r;
   logic [W-1:0]    alu_y_r;
   logic            rsp_valid_r;
   logic [IDW-1:0]  rsp_id_r;
   logic [W-1:0]    rsp_out_r;
   logic            rsp_carry_r;
`ifdef ALU_OPCHK_EN
   logic            rsp_err_r;
`endif

   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0]  gid_s;
   logic [NREQ-1:0] ready_s;
   logic            take_s;
   logic            illegal_s;
   logic [3:0]      gnt_ctrl_s;
   logic [W-1:0]    gnt_x_s;
   logic [W-1:0]    gnt_y_s;

   // Next round-robin start position after serving requester id.
   function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] id);
      if (int'(id) == NREQ - 1) begin
         return '0;
      end else begin
         return id + IDW'(1);
      end
   endfunction

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr_r),
      .grant (grant_s),
      .gid   (gid_s)
   );

   // Operand mux for the granted requester plus transfer qualification.
   always_comb begin
      gnt_ctrl_s = bus.req_ctrl[4*int'(gid_s) +: 4];
      gnt_x_s    = bus.req_x[W*int'(gid_s) +: W];
      gnt_y_s    = bus.req_y[W*int'(gid_s) +: W];
      take_s     = (state_r == ST_IDLE) && (|grant_s) && rst_n;
`ifdef ALU_OPCHK_EN
      illegal_s  = op_is_illegal(gnt_ctrl_s);
`else
      illegal_s  = 1'b0;
`endif
   end

   // Grants are only offered while idle and out of reset.
   always_comb begin
      ready_s = '0;
      if ((state_r == ST_IDLE) && rst_n) begin
         ready_s = grant_s;
      end else begin
         ready_s = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               state_s = illegal_s ? ST_RESP : ST_EXEC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_s = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand, pointer and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r       <= '0;
         op_id_r     <= '0;
         alu_ctrl_r  <= OP_NOP;
         alu_x_r     <= '0;
         alu_y_r     <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_out_r   <= '0;
         rsp_carry_r <= 1'b0;
`ifdef ALU_OPCHK_EN
         rsp_err_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (take_s) begin
                  op_id_r <= gid_s;
                  if (illegal_s) begin
                     // Answer directly; the ALU ports are left untouched.
                     rsp_valid_r <= 1'b1;
                     rsp_id_r    <= gid_s;
                     rsp_out_r   <= '0;
                     rsp_carry_r <= 1'b0;
                     ptr_r       <= ptr_after(gid_s);
`ifdef ALU_OPCHK_EN
                     rsp_err_r   <= 1'b1;
`endif
                  end else begin
                     alu_ctrl_r <= gnt_ctrl_s;
                     alu_x_r    <= gnt_x_s;
                     alu_y_r    <= gnt_y_s;
                  end
               end
            end
            ST_EXEC: begin
               rsp_valid_r <= 1'b1;
               rsp_id_r    <= op_id_r;
               rsp_out_r   <= alu_out;
               rsp_carry_r <= alu_carry;
               alu_ctrl_r  <= OP_NOP;
               ptr_r       <= ptr_after(op_id_r);
`ifdef ALU_OPCHK_EN
               rsp_err_r   <= 1'b0;
`endif
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.rsp_out   = rsp_out_r;
   assign bus.rsp_carry = rsp_carry_r;
`ifdef ALU_OPCHK_EN
   assign bus.rsp_err   = rsp_err_r;
`endif
   assign busy          = (state_r != ST_IDLE);
   assign alu_ctrl      = alu_ctrl_r;
   assign alu_x         = alu_x_r;
   assign alu_y         = alu_y_r;

endmodule
